// File: rtl/mig1_dbg_core_slave.sv
// Debug APB slave for a Mig1 core: a small register file for the debugger,
// halt/resume/single-step control, PC overwrite while halted, and a
// retired-instruction counter.
module mig1_dbg_core_slave #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int PC_WIDTH     = 8,
  parameter int HALT_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] apb_addr,
  input  logic                  apb_sel,
  input  logic                  apb_enable,
  input  logic                  apb_wr_rd,
  input  logic [DATA_WIDTH-1:0] apb_wdata,
  output logic                  apb_ready,
  output logic [DATA_WIDTH-1:0] apb_rdata,
  output logic                  core_halt_req,
  input  logic                  core_halted,
  output logic                  core_step,
  input  logic                  core_retire,
  input  logic [PC_WIDTH-1:0]   core_pc,
  output logic                  core_pc_wr_en,
  output logic [PC_WIDTH-1:0]   core_pc_wr_data
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_RESP      = 2'd1;
  localparam logic [1:0] ST_WAIT_HALT = 2'd2;

  localparam int OFF_W = ADDR_WIDTH - 2;
  localparam logic [OFF_W-1:0] OFF_CTRL    = OFF_W'(0);
  localparam logic [OFF_W-1:0] OFF_STATUS  = OFF_W'(1);
  localparam logic [OFF_W-1:0] OFF_PC      = OFF_W'(2);
  localparam logic [OFF_W-1:0] OFF_RETIRED = OFF_W'(3);
  localparam logic [OFF_W-1:0] OFF_SCRATCH = OFF_W'(4);
  localparam logic [OFF_W-1:0] OFF_ID      = OFF_W'(5);

  localparam logic [31:0] ID_VALUE = 32'h4D49_4731;
  localparam int CNT_W = (HALT_TIMEOUT < 1) ? 1 : $clog2(HALT_TIMEOUT + 1);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  halt_req_q, halt_req_d;
  logic                  step_q, step_d;
  logic                  step_pend_q, step_pend_d;
  logic                  step_done_q, step_done_d;
  logic                  timeout_q, timeout_d;
  logic                  pc_wr_en_q, pc_wr_en_d;
  logic [PC_WIDTH-1:0]   pc_wr_data_q, pc_wr_data_d;
  logic [31:0]           retired_q, retired_d;
  logic [DATA_WIDTH-1:0] scratch_q, scratch_d;

  logic [OFF_W-1:0]      offset;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  unused_addr_bits;

  assign offset           = apb_addr[ADDR_WIDTH-1:2];
  assign unused_addr_bits = ^apb_addr[1:0];

  assign apb_ready       = ready_q;
  assign apb_rdata       = rdata_q;
  assign core_halt_req   = halt_req_q;
  assign core_step       = step_q;
  assign core_pc_wr_en   = pc_wr_en_q;
  assign core_pc_wr_data = pc_wr_data_q;

  // Read mux over the register map; unmapped offsets read as zero.
  always_comb begin
    rd_val = '0;
    case (offset)
      OFF_CTRL:    rd_val = DATA_WIDTH'(halt_req_q);
      OFF_STATUS:  rd_val = DATA_WIDTH'({timeout_q, step_done_q, core_halted});
      OFF_PC:      rd_val = DATA_WIDTH'(core_pc);
      OFF_RETIRED: rd_val = DATA_WIDTH'(retired_q);
      OFF_SCRATCH: rd_val = scratch_q;
      OFF_ID:      rd_val = DATA_WIDTH'(ID_VALUE);
      default:     rd_val = '0;
    endcase
  end

  // Next-state logic: background counters first, then the transfer FSM,
  // whose register writes take priority over same-cycle background updates.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ready_d      = 1'b0;
    rdata_d      = rdata_q;
    halt_req_d   = halt_req_q;
    step_d       = 1'b0;
    step_pend_d  = step_pend_q;
    step_done_d  = step_done_q;
    timeout_d    = timeout_q;
    pc_wr_en_d   = 1'b0;
    pc_wr_data_d = pc_wr_data_q;
    retired_d    = retired_q;
    scratch_d    = scratch_q;

    if (core_retire) begin
      retired_d = retired_q + 32'd1;
      if (step_pend_q) begin
        step_done_d = 1'b1;
        step_pend_d = 1'b0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (apb_sel && apb_enable && !ready_q) begin
          state_d = ST_RESP;
          if (apb_wr_rd) begin
            case (offset)
              OFF_CTRL: begin
                if (apb_wdata[1]) begin
                  halt_req_d = 1'b0;
                end else if (apb_wdata[0]) begin
                  halt_req_d = 1'b1;
                  if (!core_halted) begin
                    state_d = ST_WAIT_HALT;
                    cnt_d   = '0;
                  end
                end
                if (apb_wdata[2] && core_halted && !apb_wdata[1]) begin
                  step_d      = 1'b1;
                  step_pend_d = 1'b1;
                end
              end
              OFF_STATUS: begin
                if (apb_wdata[1]) step_done_d = 1'b0;
                if (apb_wdata[2]) timeout_d   = 1'b0;
              end
              OFF_PC: begin
                if (core_halted) begin
                  pc_wr_en_d   = 1'b1;
                  pc_wr_data_d = apb_wdata[PC_WIDTH-1:0];
                end
              end
              OFF_RETIRED: retired_d = '0;
              OFF_SCRATCH: scratch_d = apb_wdata;
              default: ;
            endcase
          end else begin
            rdata_d = rd_val;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        ready_d = apb_sel;
      end
      ST_WAIT_HALT: begin
        if (!apb_sel) begin
          state_d = ST_IDLE;
        end else if (core_halted) begin
          state_d = ST_RESP;
        end else if (cnt_q == CNT_W'(HALT_TIMEOUT)) begin
          state_d   = ST_RESP;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      rdata_q      <= '0;
      halt_req_q   <= 1'b0;
      step_q       <= 1'b0;
      step_pend_q  <= 1'b0;
      step_done_q  <= 1'b0;
      timeout_q    <= 1'b0;
      pc_wr_en_q   <= 1'b0;
      pc_wr_data_q <= '0;
      retired_q    <= '0;
      scratch_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      rdata_q      <= rdata_d;
      halt_req_q   <= halt_req_d;
      step_q       <= step_d;
      step_pend_q  <= step_pend_d;
      step_done_q  <= step_done_d;
      timeout_q    <= timeout_d;
      pc_wr_en_q   <= pc_wr_en_d;
      pc_wr_data_q <= pc_wr_data_d;
      retired_q    <= retired_d;
      scratch_q    <= scratch_d;
    end
  end

endmodule

// File: tb/tb_mig1_dbg_core_slave.sv
// Self-checking bench for mig1_dbg_core_slave: APB master, simple core model
// and a register-level reference model kept in plain variables.
module tb_mig1_dbg_core_slave;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int PW = 8;
  localparam int HT = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] apb_addr;
  logic          apb_sel, apb_enable, apb_wr_rd;
  logic [DW-1:0] apb_wdata;
  logic          apb_ready;
  logic [DW-1:0] apb_rdata;
  logic          core_halt_req, core_halted, core_step, core_retire;
  logic [PW-1:0] core_pc;
  logic          core_pc_wr_en;
  logic [PW-1:0] core_pc_wr_data;

  int errors = 0;
  int checks = 0;

  // Reference model of the debugger-visible state.
  logic          m_halt_req;
  logic [31:0]   m_retired;
  logic [31:0]   m_scratch;

  // Pulse monitors on the core-side strobes.
  int            step_cyc = 0;
  int            pcwr_cyc = 0;
  logic [PW-1:0] pcwr_last = '0;

  always #5 clk = ~clk;

  mig1_dbg_core_slave #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .PC_WIDTH    (PW),
    .HALT_TIMEOUT(HT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .apb_addr       (apb_addr),
    .apb_sel        (apb_sel),
    .apb_enable     (apb_enable),
    .apb_wr_rd      (apb_wr_rd),
    .apb_wdata      (apb_wdata),
    .apb_ready      (apb_ready),
    .apb_rdata      (apb_rdata),
    .core_halt_req  (core_halt_req),
    .core_halted    (core_halted),
    .core_step      (core_step),
    .core_retire    (core_retire),
    .core_pc        (core_pc),
    .core_pc_wr_en  (core_pc_wr_en),
    .core_pc_wr_data(core_pc_wr_data)
  );

  always @(negedge clk) begin
    if (core_step) step_cyc <= step_cyc + 1;
    if (core_pc_wr_en) begin
      pcwr_cyc  <= pcwr_cyc + 1;
      pcwr_last <= core_pc_wr_data;
    end
  end

  // Byte address for a word offset, with random don't-care low bits.
  function automatic logic [AW-1:0] mk_addr(input int off);
    logic [2:0] o;
    logic [1:0] lo;
    o  = 3'(off);
    lo = 2'($urandom_range(0, 3));
    return {o, lo};
  endfunction

  // One APB transfer; lat counts rising edges from access start to ready
  // (-1 if ready never arrives within the bound).
  task automatic apb_xfer(input logic wr, input int off, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
    @(negedge clk);
    apb_sel = 1'b1; apb_enable = 1'b0; apb_wr_rd = wr;
    apb_addr = mk_addr(off); apb_wdata = wd;
    @(negedge clk);
    apb_enable = 1'b1;
    lat = -1; rd = '0;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk); #1;
      if (apb_ready) begin
        lat = i; rd = apb_rdata;
        break;
      end
    end
    apb_sel = 1'b0; apb_enable = 1'b0;
  endtask

  task automatic retire_once();
    @(negedge clk); core_retire = 1'b1;
    @(negedge clk); core_retire = 1'b0;
    m_retired = m_retired + 32'd1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({apb_ready, apb_rdata, core_halt_req, core_step, core_pc_wr_en, core_pc_wr_data} !== '0)
      begin errors++; $display("FAIL reset_outputs: got ready=%b rdata=%h halt=%b step=%b pcwe=%b pcwd=%h required all 0",
        apb_ready, apb_rdata, core_halt_req, core_step, core_pc_wr_en, core_pc_wr_data); end
    @(negedge clk); rst_n = 1'b1;
    m_halt_req = 1'b0; m_retired = '0; m_scratch = '0;
  endtask

  task automatic test_id_and_unmapped();
    logic [31:0] rd; int lat;
    apb_xfer(1'b0, 5, '0, rd, lat);
    checks++;
    if (rd !== 32'h4D49_4731 || lat != 2) begin errors++;
      $display("FAIL id_read: got %h lat %0d required 4d494731 lat 2", rd, lat); end
    apb_xfer(1'b1, 5, $urandom, rd, lat);
    apb_xfer(1'b0, 5, '0, rd, lat);
    checks++;
    if (rd !== 32'h4D49_4731 || lat != 2) begin errors++;
      $display("FAIL id_readonly: got %h lat %0d required 4d494731 lat 2", rd, lat); end
    for (int off = 6; off <= 7; off++) begin
      apb_xfer(1'b1, off, $urandom | 32'h1, rd, lat);
      apb_xfer(1'b0, off, '0, rd, lat);
      checks++;
      if (rd !== 32'h0 || lat != 2) begin errors++;
        $display("FAIL unmapped_%0d: got %h lat %0d required 0 lat 2", off, rd, lat); end
    end
  endtask

  task automatic test_halt_wait();
    logic [31:0] rd; int lat;
    core_halted = 1'b0;
    fork
      apb_xfer(1'b1, 0, 32'h1, rd, lat);
      begin
        wait (apb_enable === 1'b1);
        repeat (4) @(posedge clk);
        #1 core_halted = 1'b1;
      end
    join
    m_halt_req = 1'b1;
    // Core stops after 4 edges; the slave sees it on the 5th, ready on the 6th.
    checks++;
    if (lat != 6) begin errors++; $display("FAIL halt_wait_latency: got %0d required 6", lat); end
    checks++;
    if (core_halt_req !== m_halt_req) begin errors++;
      $display("FAIL halt_req_set: got %b required %b", core_halt_req, m_halt_req); end
    apb_xfer(1'b0, 1, '0, rd, lat);
    checks++;
    if (rd !== 32'h1 || lat != 2) begin errors++;
      $display("FAIL status_halted: got %h lat %0d required 1 lat 2", rd, lat); end
    apb_xfer(1'b0, 0, '0, rd, lat);
    checks++;
    if (rd !== 32'h1 || lat != 2) begin errors++;
      $display("FAIL ctrl_read: got %h lat %0d required 1 lat 2", rd, lat); end
  endtask

  task automatic test_halt_timeout();
    logic [31:0] rd; int lat;
    core_halted = 1'b0;
    apb_xfer(1'b1, 0, 32'h2, rd, lat);
    m_halt_req = 1'b0;
    checks++;
    if (core_halt_req !== m_halt_req || lat != 2) begin errors++;
      $display("FAIL resume: got halt_req=%b lat %0d required 0 lat 2", core_halt_req, lat); end
    apb_xfer(1'b1, 0, 32'h1, rd, lat);
    m_halt_req = 1'b1;
    // Normal two-edge latency plus HALT_TIMEOUT+1 cycles spent waiting.
    checks++;
    if (lat != HT + 3) begin errors++;
      $display("FAIL timeout_latency: got %0d required %0d", lat, HT + 3); end
    apb_xfer(1'b0, 1, '0, rd, lat);
    checks++;
    if (rd !== 32'h4 || lat != 2) begin errors++;
      $display("FAIL status_timeout: got %h lat %0d required 4 lat 2", rd, lat); end
    apb_xfer(1'b1, 1, 32'h4, rd, lat);
    apb_xfer(1'b0, 1, '0, rd, lat);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL timeout_clear: got %h required 0", rd); end
    apb_xfer(1'b1, 0, 32'h3, rd, lat);
    m_halt_req = 1'b0;
    checks++;
    if (core_halt_req !== m_halt_req || lat != 2) begin errors++;
      $display("FAIL resume_over_halt: got halt_req=%b lat %0d required 0 lat 2", core_halt_req, lat); end
  endtask

  task automatic test_pc();
    logic [31:0] rd; int lat; int c0; logic [PW-1:0] pcv;
    core_halted = 1'b1;
    pcv = PW'($urandom);
    core_pc = pcv;
    apb_xfer(1'b0, 2, '0, rd, lat);
    checks++;
    if (rd !== {24'h0, pcv} || lat != 2) begin errors++;
      $display("FAIL pc_read: got %h lat %0d required %h lat 2", rd, lat, {24'h0, pcv}); end
    c0 = pcwr_cyc;
    apb_xfer(1'b1, 2, {24'($urandom), 8'h40}, rd, lat);
    @(negedge clk); @(negedge clk);
    checks++;
    if (pcwr_cyc != c0 + 1 || pcwr_last !== 8'h40) begin errors++;
      $display("FAIL pc_write_halted: got %0d pulses data %h required 1 pulse data 40", pcwr_cyc - c0, pcwr_last); end
    core_halted = 1'b0;
    c0 = pcwr_cyc;
    apb_xfer(1'b1, 2, 32'h41, rd, lat);
    @(negedge clk); @(negedge clk);
    checks++;
    if (pcwr_cyc != c0) begin errors++;
      $display("FAIL pc_write_running: got %0d pulses required 0", pcwr_cyc - c0); end
  endtask

  task automatic test_step();
    logic [31:0] rd; int lat; int s0;
    core_halted = 1'b1;
    s0 = step_cyc;
    apb_xfer(1'b1, 0, 32'h4, rd, lat);
    @(negedge clk);
    checks++;
    if (step_cyc != s0 + 1 || lat != 2) begin errors++;
      $display("FAIL step_pulse: got %0d cycles lat %0d required 1 lat 2", step_cyc - s0, lat); end
    apb_xfer(1'b0, 1, '0, rd, lat);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL step_done_early: got %h required 1", rd); end
    retire_once();
    apb_xfer(1'b0, 1, '0, rd, lat);
    checks++;
    if (rd !== 32'h3) begin errors++; $display("FAIL step_done: got %h required 3", rd); end
    apb_xfer(1'b1, 1, 32'h2, rd, lat);
    apb_xfer(1'b0, 1, '0, rd, lat);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL step_done_clear: got %h required 1", rd); end
    s0 = step_cyc;
    apb_xfer(1'b1, 0, 32'h6, rd, lat);
    m_halt_req = 1'b0;
    @(negedge clk);
    checks++;
    if (step_cyc != s0 || core_halt_req !== m_halt_req) begin errors++;
      $display("FAIL step_with_resume: got %0d pulses halt_req=%b required 0 pulses halt_req=0", step_cyc - s0, core_halt_req); end
    core_halted = 1'b0;
    apb_xfer(1'b1, 0, 32'h4, rd, lat);
    @(negedge clk);
    checks++;
    if (step_cyc != s0) begin errors++;
      $display("FAIL step_running: got %0d pulses required 0", step_cyc - s0); end
  endtask

  task automatic test_random_regs();
    logic [31:0] rd, wd; int lat; int n;
    apb_xfer(1'b1, 3, $urandom, rd, lat);
    m_retired = '0;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 20);
      for (int c = 0; c < n; c++) begin
        @(negedge clk);
        core_retire = 1'($urandom);
        if (core_retire) m_retired = m_retired + 32'd1;
      end
      @(negedge clk); core_retire = 1'b0;
      apb_xfer(1'b0, 3, '0, rd, lat);
      checks++;
      if (rd !== m_retired || lat != 2) begin errors++;
        $display("FAIL retired_%0d: got %h lat %0d required %h lat 2", it, rd, lat, m_retired); end
      wd = $urandom;
      apb_xfer(1'b1, 4, wd, rd, lat);
      m_scratch = wd;
      apb_xfer(1'b0, 4, '0, rd, lat);
      checks++;
      if (rd !== m_scratch || lat != 2) begin errors++;
        $display("FAIL scratch_%0d: got %h lat %0d required %h lat 2", it, rd, lat, m_scratch); end
    end
    apb_xfer(1'b0, 0, '0, rd, lat);
    checks++;
    if (rd !== {31'h0, m_halt_req}) begin errors++;
      $display("FAIL ctrl_model: got %h required %h", rd, {31'h0, m_halt_req}); end
  endtask

  task automatic test_retired_wrap();
    logic [31:0] rd; int lat;
    @(negedge clk);
    force dut.retired_q = 32'hFFFF_FFFF;
    #1 release dut.retired_q;
    m_retired = 32'hFFFF_FFFF;
    apb_xfer(1'b0, 3, '0, rd, lat);
    checks++;
    if (rd !== m_retired) begin errors++; $display("FAIL retired_preload: got %h required ffffffff", rd); end
    retire_once();
    apb_xfer(1'b0, 3, '0, rd, lat);
    checks++;
    if (rd !== m_retired) begin errors++; $display("FAIL retired_wrap: got %h required %h", rd, m_retired); end
  endtask

  task automatic test_reset_in_wait_halt();
    logic [31:0] rd; int lat;
    core_halted = 1'b0;
    apb_xfer(1'b1, 4, 32'hA5A5_0F0F, rd, lat);
    @(negedge clk);
    apb_sel = 1'b1; apb_enable = 1'b0; apb_wr_rd = 1'b1;
    apb_addr = mk_addr(0); apb_wdata = 32'h1;
    @(negedge clk); apb_enable = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (apb_ready !== 1'b0 || core_halt_req !== 1'b1) begin errors++;
      $display("FAIL wait_halt_pending: got ready=%b halt_req=%b required 0 1", apb_ready, core_halt_req); end
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({apb_ready, apb_rdata, core_halt_req, core_step, core_pc_wr_en, core_pc_wr_data} !== '0)
      begin errors++; $display("FAIL reset_in_wait: got ready=%b rdata=%h halt=%b step=%b pcwe=%b pcwd=%h required all 0",
        apb_ready, apb_rdata, core_halt_req, core_step, core_pc_wr_en, core_pc_wr_data); end
    apb_sel = 1'b0; apb_enable = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    m_halt_req = 1'b0; m_retired = '0; m_scratch = '0;
    repeat (HT + 4) @(negedge clk);
    apb_xfer(1'b0, 1, '0, rd, lat);
    checks++;
    if (rd !== 32'h0 || lat != 2) begin errors++;
      $display("FAIL status_after_reset: got %h lat %0d required 0 lat 2", rd, lat); end
    apb_xfer(1'b0, 4, '0, rd, lat);
    checks++;
    if (rd !== m_scratch) begin errors++; $display("FAIL scratch_after_reset: got %h required 0", rd); end
    apb_xfer(1'b0, 3, '0, rd, lat);
    checks++;
    if (rd !== m_retired) begin errors++; $display("FAIL retired_after_reset: got %h required 0", rd); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    apb_addr = '0; apb_sel = 1'b0; apb_enable = 1'b0; apb_wr_rd = 1'b0; apb_wdata = '0;
    core_halted = 1'b0; core_retire = 1'b0; core_pc = '0;
    m_halt_req = 1'b0; m_retired = '0; m_scratch = '0;
    test_reset();
    test_id_and_unmapped();
    test_halt_wait();
    test_halt_timeout();
    test_pc();
    test_step();
    test_random_regs();
    test_retired_wrap();
    test_reset_in_wait_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mig1_dbg_core_slave.md
Name: mig1_dbg_core_slave

Overview:
Debug APB slave inside each Mig1 core, sitting directly downstream of the debug APB bus; it is the endpoint that answers that bus's s2m_ready/s2m_data.
- Decodes APB transfers into a small debug register file.
- Drives halt, resume and single-step control into the core pipeline, and reads/writes the core PC while the core is halted.
- Counts retired instructions for the debugger.

Parameters:
ADDR_WIDTH, 5, APB byte-address width; only word-aligned offsets are decoded
DATA_WIDTH, 32, APB read/write data width
PC_WIDTH, 8, core PC width
HALT_TIMEOUT, 15, max cycles to wait for core_halted after a halt request before completing anyway

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
apb_addr  in  ADDR_WIDTH  byte address of transfer
apb_sel  in  1  slave selected
apb_enable  in  1  access phase of transfer
apb_wr_rd  in  1  1=write, 0=read
apb_wdata  in  DATA_WIDTH  write data
apb_ready  out  1  transfer completes this cycle
apb_rdata  out  DATA_WIDTH  read data, valid when apb_ready=1 on a read
core_halt_req  out  1  level request for the core to stop issuing
core_halted  in  1  core is stopped at an instruction boundary
core_step  out  1  one-cycle pulse: execute exactly one instruction while halted
core_retire  in  1  one instruction retired this cycle
core_pc  in  PC_WIDTH  current core PC
core_pc_wr_en  out  1  one-cycle PC overwrite strobe
core_pc_wr_data  out  PC_WIDTH  new PC value

Behaviour:
- Interface: one clock, clk. rst_n is synchronous and active-low: it is sampled only on the rising edge of clk.
- Reset values: apb_ready=0, apb_rdata=0, core_halt_req=0, core_step=0, core_pc_wr_en=0, core_pc_wr_data=0, FSM=IDLE, all registers 0.
- Register map (offset = apb_addr[ADDR_WIDTH-1:2]; apb_addr[1:0] ignored):
  - 0 CTRL, W: bit0 HALT (sets halt_req), bit1 RESUME (clears halt_req), bit2 STEP. Reads return {29'b0, 0, 0, halt_req}.
  - 1 STATUS, R: bit0 core_halted, bit1 step_done (sticky), bit2 halt_timeout (sticky). Writing 1 to bit1 or bit2 clears that bit.
  - 2 PC, R/W: reads return zero-extended core_pc. Write while core_halted=1 pulses core_pc_wr_en for 1 cycle with wdata[PC_WIDTH-1:0]. Write while running is ignored.
  - 3 RETIRED, R: 32-bit retired-instruction counter; increments on core_retire, wraps 0xFFFFFFFF->0. Writing clears it; a same-cycle retire is lost.
  - 4 SCRATCH, R/W: plain 32-bit register.
  - 5 ID, R: 0x4D494731.
  - 6-7: read 0, writes ignored.
- FSM states:
  - IDLE: waits for apb_sel=1, apb_enable=1, apb_ready=0. Then performs the register action. Goes to WAIT_HALT if the write sets HALT and core_halted=0, otherwise to RESP.
  - RESP: apb_ready=1 for exactly one cycle, rdata registered, then IDLE. Minimum latency is one wait state: ready appears 2 cycles after the access phase starts.
  - WAIT_HALT: counter counts up from 0. Goes to RESP when core_halted=1, or when the counter reaches HALT_TIMEOUT (also sets halt_timeout).
- CTRL bit priority in one write: RESUME > HALT. STEP is honoured only if core_halted=1 and RESUME=0. It pulses core_step for 1 cycle and sets step_done on the next core_retire.
- apb_sel dropping mid-transfer: FSM returns to IDLE, no response is issued, and any side effect already taken is kept.
- rst_n low in any state: reset values apply on the next clock, including abandoning WAIT_HALT.
- apb_sel=1 with apb_enable=0 (setup phase): no action.

Test Plan:
- Read ID (offset 5) -> apb_ready=1 exactly 2 cycles after the access phase starts, apb_rdata=0x4D494731.
- Write CTRL=0x1; core model asserts core_halted 4 cycles later -> apb_ready waits for it; STATUS reads 0x1; core_halt_req=1.
- Write CTRL=0x1 with core_halted tied 0 -> ready after HALT_TIMEOUT+1 cycles; STATUS bit2=1; writing STATUS=0x4 clears it.
- While halted, write PC=0x40 -> single core_pc_wr_en pulse with data 0x40. While running, write PC=0x40 -> no pulse.
- While halted, write CTRL=0x4 then retire once -> one core_step pulse; STATUS=0x3. Write CTRL=0x6 -> no step pulse, halt_req=0.
- Preload RETIRED to wrap via 0xFFFFFFFF retires (or force) -> one more retire gives 0. Assert rst_n=0 during WAIT_HALT -> all outputs 0 next cycle.
